fm_demod: RTL and testbench
===========================

FM_DEMOD -- requirements
Module: fm_demod

Interface
REQ-001 Parameter: GAIN, 32'sd758, signed quantized (10 fractional bits) audio gain applied to each angle.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_real, in_imag  input  32 each  signed quantized I/Q sample at head of first-word-fall-through input FIFO.
REQ-005 in_empty  input  1  input FIFO empty; in_rd_en  output  1  pops one I/Q sample.
REQ-006 x, y  output  32 each  signed conjugate-product real/imag to the arctangent stage.
REQ-007 demod_data_valid  output  1  one-cycle start pulse to the arctangent stage.
REQ-008 divider_ready  input  1  arctangent stage idle, accepts a start pulse.
REQ-009 qarctan_data  input  32  signed angle result; qarctan_done  input  1  result valid this cycle.
REQ-010 out_full  input  1  output FIFO full; out_wr_en  output  1  writes dout; dout  output  32  demodulated audio sample.

Function
REQ-011 DEQ(v) SHALL mean signed divide by 1024 truncating toward zero, applied to the full 64-bit signed product, low 32 bits kept.
REQ-012 With prev = previous accepted sample (pr, pi) and cur = (cr, ci): x SHALL = DEQ(pr*cr) + DEQ(pi*ci); y SHALL = DEQ(pr*ci) - DEQ(pi*cr); 32-bit wrap on add/sub.
REQ-013 FSM states IDLE, CALC, ISSUE, WAIT, WRITE; reset state IDLE.
REQ-014 IDLE: if !in_empty, in_rd_en=1 for that cycle, register cur <= {in_real,in_imag}, go CALC; else stay, in_rd_en=0.
REQ-015 CALC (1 cycle): register x, y per REQ-012, prev <= cur, go ISSUE.
REQ-016 ISSUE: when divider_ready=1, demod_data_valid=1 for exactly that cycle, go WAIT; else hold in ISSUE with demod_data_valid=0.
REQ-017 x and y SHALL remain stable from CALC exit until the cycle after qarctan_done (arctangent stage reads them combinationally while working).
REQ-018 WAIT: on qarctan_done=1, register result = DEQ(GAIN * qarctan_data), go WRITE; qarctan_done in any other state SHALL be ignored.
REQ-019 WRITE: when out_full=0, out_wr_en=1 with dout=result for one cycle, go IDLE; while out_full=1 hold, out_wr_en=0, dout stable.
REQ-020 Minimum latency from in_rd_en to demod_data_valid SHALL be 2 cycles; from qarctan_done to out_wr_en 1 cycle; new in_rd_en no earlier than the cycle after out_wr_en.
REQ-021 Exactly one out_wr_en per in_rd_en; no sample dropped or duplicated under any in_empty/out_full/divider_ready pattern.
REQ-022 First sample after reset SHALL use prev = (0,0), yielding x=y=0.
REQ-023 in_rd_en, demod_data_valid, out_wr_en SHALL be 0 in every state not listed as asserting them.

Reset
REQ-024 reset=1 at a clock edge SHALL force IDLE; prev, cur, x, y, result, dout to 0; in_rd_en, demod_data_valid, out_wr_en to 0.
REQ-025 Reset mid-operation (any state) SHALL discard the in-flight sample; no out_wr_en for it.

Configuration
REQ-026 Macro FM_DEMOD_SAT_EN defined: result SHALL saturate to [-32768, 32767] before registration in WRITE.
REQ-027 Macro FM_DEMOD_SAT_EN undefined: result SHALL be the wrapped low 32 bits of DEQ(GAIN*qarctan_data).

Verification
REQ-028 Reset then sample (1024,0) then (0,1024): first issue x=0,y=0; second issue x=0, y=1024.
REQ-029 Arctangent stub returns 0x324 (804), GAIN=758 -> dout=595 one cycle after qarctan_done; returns -804 -> dout=-595.
REQ-030 Stub returns 0x00100000, GAIN=758: FM_DEMOD_SAT_EN -> dout=32767; undefined -> dout=0x000BD800.
REQ-031 divider_ready held 0 for 5 cycles in ISSUE -> no demod_data_valid, x/y stable; ready rises -> single pulse.
REQ-032 out_full held 1 for 4 cycles in WRITE -> no out_wr_en, no in_rd_en, dout stable; 100 random samples with random stalls -> 100 writes, order preserved.
REQ-033 reset asserted during WAIT -> IDLE next cycle, no out_wr_en, next sample uses prev=(0,0).

Source files
------------

// File: rtl/fm_demod.sv
// fm_demod: FM discriminator. Conjugate-multiplies consecutive I/Q samples, hands (x,y)
// to an external arctangent stage and scales the returned angle by GAIN (Q10).
// Optional macro FM_DEMOD_SAT_EN clamps the audio result to [-32768, 32767].
module fm_demod #(
  parameter int DATA_W = 32,
  parameter int COEF_W = 32,
  parameter logic signed [COEF_W-1:0] GAIN = 32'sd758
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] in_real,
  input  logic signed [DATA_W-1:0] in_imag,
  input  logic                     in_empty,
  output logic                     in_rd_en,
  output logic signed [DATA_W-1:0] x,
  output logic signed [DATA_W-1:0] y,
  output logic                     demod_data_valid,
  input  logic                     divider_ready,
  input  logic signed [DATA_W-1:0] qarctan_data,
  input  logic                     qarctan_done,
  input  logic                     out_full,
  output logic                     out_wr_en,
  output logic signed [DATA_W-1:0] dout
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int FRAC   = 10;
  localparam logic signed [PROD_W-1:0] TRUNC_BIAS = {{(PROD_W-FRAC){1'b0}}, {FRAC{1'b1}}};
  localparam logic signed [PROD_W-1:0] GAIN_EXT   = {{(PROD_W-COEF_W){GAIN[COEF_W-1]}}, GAIN};

  typedef enum logic [2:0] {IDLE, CALC, ISSUE, WAIT, WRITE} state_t;

  state_t                   state;
  logic signed [DATA_W-1:0] cur_re_p0, cur_im_p0;
  logic signed [DATA_W-1:0] prev_re_p1, prev_im_p1;
  logic signed [DATA_W-1:0] x_p1, y_p1;
  logic signed [DATA_W-1:0] result_p2;
  logic signed [DATA_W-1:0] x_nxt, y_nxt, res_nxt;

  function automatic logic signed [PROD_W-1:0] sext(input logic signed [DATA_W-1:0] v);
    sext = {{DATA_W{v[DATA_W-1]}}, v};
  endfunction

  function automatic logic signed [PROD_W-1:0] mul(input logic signed [PROD_W-1:0] a,
                                                   input logic signed [PROD_W-1:0] b);
    mul = a * b;
  endfunction

  // Divide by 2^FRAC truncating toward zero: bias negatives before the arithmetic shift.
  function automatic logic signed [PROD_W-1:0] quot(input logic signed [PROD_W-1:0] p);
    logic signed [PROD_W-1:0] adj;
    adj  = p[PROD_W-1] ? p + TRUNC_BIAS : p;
    quot = adj >>> FRAC;
  endfunction

  function automatic logic signed [DATA_W-1:0] deq(input logic signed [PROD_W-1:0] p);
    deq = DATA_W'(quot(p));
  endfunction

`ifdef FM_DEMOD_SAT_EN
  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'(32'sd32767);
  localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-32'sd32768);

  // Clamp the full-precision quotient so a wrapped value can never flip sign.
  function automatic logic signed [DATA_W-1:0] scale_angle(input logic signed [DATA_W-1:0] a);
    logic signed [PROD_W-1:0] q;
    q = quot(mul(GAIN_EXT, sext(a)));
    if (q > SAT_MAX)      scale_angle = DATA_W'(SAT_MAX);
    else if (q < SAT_MIN) scale_angle = DATA_W'(SAT_MIN);
    else                  scale_angle = DATA_W'(q);
  endfunction
`else
  function automatic logic signed [DATA_W-1:0] scale_angle(input logic signed [DATA_W-1:0] a);
    scale_angle = deq(mul(GAIN_EXT, sext(a)));
  endfunction
`endif

  always_comb begin
    x_nxt   = deq(mul(sext(prev_re_p1), sext(cur_re_p0)))
            + deq(mul(sext(prev_im_p1), sext(cur_im_p0)));
    y_nxt   = deq(mul(sext(prev_re_p1), sext(cur_im_p0)))
            - deq(mul(sext(prev_im_p1), sext(cur_re_p0)));
    res_nxt = scale_angle(qarctan_data);
  end

  // Strobes are decoded from state so each handshake completes in the cycle it is offered.
  assign in_rd_en         = (state == IDLE)  && !in_empty;
  assign demod_data_valid = (state == ISSUE) && divider_ready;
  assign out_wr_en        = (state == WRITE) && !out_full;
  assign x                = x_p1;
  assign y                = y_p1;
  assign dout             = result_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cur_re_p0  <= '0;
      cur_im_p0  <= '0;
      prev_re_p1 <= '0;
      prev_im_p1 <= '0;
      x_p1       <= '0;
      y_p1       <= '0;
      result_p2  <= '0;
    end else begin
      case (state)
        // p0: capture the FIFO head
        IDLE: if (!in_empty) begin
          cur_re_p0 <= in_real;
          cur_im_p0 <= in_imag;
          state     <= CALC;
        end
        // p1: conjugate product; x/y hold until the next sample reaches this stage
        CALC: begin
          x_p1       <= x_nxt;
          y_p1       <= y_nxt;
          prev_re_p1 <= cur_re_p0;
          prev_im_p1 <= cur_im_p0;
          state      <= ISSUE;
        end
        ISSUE: if (divider_ready) state <= WAIT;
        // p2: scale the returned angle
        WAIT: if (qarctan_done) begin
          result_p2 <= res_nxt;
          state     <= WRITE;
        end
        WRITE: if (!out_full) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fm_demod.sv
// Bench for fm_demod: FIFO/arctangent/output-FIFO environment driven cycle by cycle,
// a directed vector table, multi-cycle corner sequences and a randomized run.
module tb_fm_demod;

  localparam int GAIN = 758;
`ifdef FM_DEMOD_SAT_EN
  localparam bit SAT  = 1'b1;
  localparam int BIG  = 32767;
  localparam int NBIG = -32768;
`else
  localparam bit SAT  = 1'b0;
  localparam int BIG  = 32'h000BD800;
  localparam int NBIG = -776192;
`endif

  logic clk = 1'b0;
  logic reset;
  logic signed [31:0] in_real, in_imag, qarctan_data;
  logic in_empty, divider_ready, qarctan_done, out_full;
  logic in_rd_en, demod_data_valid, out_wr_en;
  logic signed [31:0] x, y, dout;

  fm_demod #(.GAIN(32'sd758)) dut (
    .clk(clk), .reset(reset),
    .in_real(in_real), .in_imag(in_imag), .in_empty(in_empty), .in_rd_en(in_rd_en),
    .x(x), .y(y), .demod_data_valid(demod_data_valid), .divider_ready(divider_ready),
    .qarctan_data(qarctan_data), .qarctan_done(qarctan_done),
    .out_full(out_full), .out_wr_en(out_wr_en), .dout(dout)
  );

  always #5 clk = ~clk;

  typedef struct { int r; int i; } smp_t;
  typedef struct { int x; int y; int atan; int dout; } exp_t;
  typedef struct { int r; int i; int atan; int ex; int ey; int ed; } vec_t;

  smp_t smp_q[$];
  exp_t iss_q[$];
  int   wr_q[$];

  int checks, errors;
  int in_stall, rdy_stall, full_stall, junk;
  bit busy;
  int cnt, cur_atan, hold_x, hold_y;
  int rd_age, done_age, outstanding;
  int n_rd, n_wr, n_vld, n_done;
  int m_pr, m_pi;

  task automatic chk(string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: exact integer arithmetic, SV division truncates toward zero.
  function automatic int deq(longint p);
    return int'(p / 64'sd1024);
  endfunction

  function automatic int audio(int a);
    longint q;
    q = (longint'(GAIN) * longint'(a)) / 64'sd1024;
    if (SAT) begin
      if (q > 32767) q = 32767;
      else if (q < -32768) q = -32768;
    end
    return int'(q);
  endfunction

  task automatic push_raw(int r, int i, int atan, int ex, int ey, int ed);
    smp_t s;
    exp_t e;
    s.r = r; s.i = i;
    e.x = ex; e.y = ey; e.atan = atan; e.dout = ed;
    smp_q.push_back(s);
    iss_q.push_back(e);
    m_pr = r; m_pi = i;
  endtask

  task automatic push_model(int r, int i, int atan);
    int ex, ey;
    ex = deq(longint'(m_pr) * longint'(r)) + deq(longint'(m_pi) * longint'(i));
    ey = deq(longint'(m_pr) * longint'(i)) - deq(longint'(m_pi) * longint'(r));
    push_raw(r, i, atan, ex, ey, audio(atan));
  endtask

  // One clock of environment: drive at negedge, observe combinational strobes just after.
  task automatic cycle();
    bit   fire;
    exp_t e;
    int   w;
    @(negedge clk);
    in_empty = (smp_q.size() == 0) || ($urandom_range(99) < in_stall);
    if (smp_q.size() != 0) begin
      in_real = smp_q[0].r;
      in_imag = smp_q[0].i;
    end
    divider_ready = !busy && ($urandom_range(99) >= rdy_stall);
    out_full      = ($urandom_range(99) < full_stall);
    fire = busy && (cnt == 0);
    if (fire) begin
      qarctan_done = 1'b1;
      qarctan_data = cur_atan;
    end else if (!busy && ($urandom_range(99) < junk)) begin
      qarctan_done = 1'b1;
      qarctan_data = $urandom;
    end else begin
      qarctan_done = 1'b0;
    end
    #1;
    if (in_rd_en) begin
      chk("rd_one_in_flight", outstanding, 0);
      chk("rd_when_empty", in_empty, 0);
      if (smp_q.size() != 0) void'(smp_q.pop_front());
      outstanding++; n_rd++; rd_age = 0;
    end
    if (rd_age == 2 && divider_ready) chk("lat_rd_to_issue", demod_data_valid, 1);
    if (demod_data_valid) begin
      n_vld++;
      chk("issue_while_busy", busy, 0);
      chk("issue_pending", iss_q.size() != 0, 1);
      if (iss_q.size() != 0) begin
        e = iss_q.pop_front();
        chk("x", x, e.x);
        chk("y", y, e.y);
        busy = 1'b1; cnt = $urandom_range(3); cur_atan = e.atan;
        hold_x = x; hold_y = y;
        wr_q.push_back(e.dout);
      end
    end
    if (fire) begin
      chk("x_stable", x, hold_x);
      chk("y_stable", y, hold_y);
      busy = 1'b0; done_age = 0; n_done++;
    end else if (busy && cnt > 0 && !demod_data_valid) begin
      cnt--;
    end
    if (done_age == 1 && !out_full) chk("lat_done_to_write", out_wr_en, 1);
    if (out_full) chk("no_write_when_full", out_wr_en, 0);
    if (out_wr_en) begin
      chk("write_pending", wr_q.size() != 0, 1);
      if (wr_q.size() != 0) begin
        w = wr_q.pop_front();
        chk("dout", dout, w);
      end
      outstanding--; n_wr++;
    end
    if (rd_age >= 0) rd_age++;
    if (done_age >= 0) done_age++;
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while ((smp_q.size() != 0 || iss_q.size() != 0 || wr_q.size() != 0 || busy) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_done", smp_q.size() + iss_q.size() + wr_q.size(), 0);
  endtask

  task automatic apply_reset(int n);
    @(negedge clk);
    reset = 1'b1; in_empty = 1'b1; qarctan_done = 1'b0; divider_ready = 1'b1;
    out_full = 1'b0; in_real = '0; in_imag = '0; qarctan_data = '0;
    #1 chk("wr_during_reset", out_wr_en, 0);
    repeat (n) @(negedge clk);
    reset = 1'b0;
    smp_q.delete(); iss_q.delete(); wr_q.delete();
    busy = 1'b0; cnt = 0; rd_age = -1; done_age = -1; outstanding = 0;
    m_pr = 0; m_pi = 0;
    #1;
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_dout", dout, 0);
    chk("rst_rd_en", in_rd_en, 0);
    chk("rst_valid", demod_data_valid, 0);
    chk("rst_wr_en", out_wr_en, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[6];
    int   sx, sy, sd, r0, w0, v0, n;

    checks = 0; errors = 0;
    reset = 1'b1; in_empty = 1'b1; divider_ready = 1'b0; qarctan_done = 1'b0;
    out_full = 1'b0; in_real = '0; in_imag = '0; qarctan_data = '0;
    rd_age = -1; done_age = -1;
    in_stall = 0; rdy_stall = 0; full_stall = 0; junk = 0;

    tbl[0] = '{1024, 0, 804, 0, 0, 595};
    tbl[1] = '{0, 1024, -804, 0, 1024, -595};
    tbl[2] = '{-2048, 512, 32'h00100000, 512, 2048, BIG};
    tbl[3] = '{3, -5, -32'sh00100000, -8, 9, NBIG};
    tbl[4] = '{7, 1, -1, 0, 0, 0};
    tbl[5] = '{32'sh7fffffff, 32'sh7fffffff, 2, 16777214, 12582912, 1};

    apply_reset(2);

    for (int k = 0; k < 6; k++) begin
      push_raw(tbl[k].r, tbl[k].i, tbl[k].atan, tbl[k].ex, tbl[k].ey, tbl[k].ed);
      drain(200);
    end

    // Arctangent stage busy for 5 ISSUE cycles.
    rdy_stall = 100;
    push_model(12345, -6789, 300);
    cycle();
    cycle();
    cycle();
    sx = x; sy = y; v0 = n_vld;
    repeat (4) cycle();
    chk("hold_no_valid", n_vld, v0);
    chk("hold_x_stable", x, sx);
    chk("hold_y_stable", y, sy);
    rdy_stall = 0;
    drain(200);
    chk("hold_single_pulse", n_vld, v0 + 1);

    // Output FIFO full for 4 WRITE cycles with another sample waiting.
    full_stall = 100;
    push_model(-4000, 2500, -1234);
    push_model(100, 200, 5000);
    n = 0;
    v0 = n_done;
    while (n_done == v0 && n < 50) begin
      cycle();
      n++;
    end
    chk("full_reached_write", n_done, v0 + 1);
    r0 = n_rd; w0 = n_wr;
    cycle();
    sd = dout;
    repeat (3) cycle();
    chk("full_no_write", n_wr, w0);
    chk("full_no_read", n_rd, r0);
    chk("full_dout_stable", dout, sd);
    full_stall = 0;
    drain(200);

    // Reset while the arctangent stage is working.
    push_model(5000, 7000, 900);
    n = 0;
    v0 = n_vld;
    while (n_vld == v0 && n < 50) begin
      cycle();
      n++;
    end
    chk("wait_reached", n_vld, v0 + 1);
    cnt = 5;
    cycle();
    apply_reset(1);
    push_model(-3000, 4000, -2000);
    r0 = n_rd;
    cycle();
    chk("rd_after_reset", n_rd, r0 + 1);
    drain(200);

    // Randomized traffic with stalls and stray done pulses.
    in_stall = 30; rdy_stall = 30; full_stall = 30; junk = 10;
    w0 = n_wr;
    for (int k = 0; k < 100; k++) begin
      int r, i, a;
      r = ($urandom_range(3) == 0) ? int'($urandom) : int'($urandom_range(65535)) - 32768;
      i = ($urandom_range(3) == 0) ? int'($urandom) : int'($urandom_range(65535)) - 32768;
      a = ($urandom_range(1) == 0) ? int'($urandom) : int'($urandom_range(8191)) - 4096;
      push_model(r, i, a);
    end
    drain(20000);
    chk("random_writes", n_wr - w0, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
